// File: rtl/multicycle_datapath.sv
// Multicycle CPU datapath: PC/IR/MDR/A/B/ALUOut registers, a register file and an 8-op ALU.
// All sequencing comes from the external control FSM; this block has no state machine and never stalls.
module multicycle_datapath #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             iord,
    input  logic             mem_wr,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic [2:0]       alu_op,
    input  logic             ir_write,
    input  logic             reg_write,
    input  logic             reg_dst,
    input  logic             mem_to_reg,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero,
    output logic             alu_ovf,
    output logic             alu_eq,
    output logic             alu_gt,
    output logic             alu_lt
);

    localparam int IDXW = $clog2(NREGS);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_AND  = 3'd3,
        OP_INC  = 3'd4,
        OP_NEG  = 3'd5,
        OP_XOR  = 3'd6,
        OP_COMP = 3'd7
    } alu_op_t;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_aluout;
    logic [WIDTH-1:0] r_rf [NREGS];

    logic [IDXW-1:0]  w_rs;
    logic [IDXW-1:0]  w_rt;
    logic [IDXW-1:0]  w_rd;
    logic [IDXW-1:0]  w_dst;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;

    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_dst   = reg_dst ? w_rd : w_rt;
    assign w_wdata = mem_to_reg ? r_mdr : r_aluout;
    assign w_sext  = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};

    // Operand muxes
    assign w_op_a = alu_src_a ? r_a : r_pc;

    always_comb begin
        w_op_b = r_b;
        case (alu_src_b)
            2'd0:    w_op_b = r_b;
            2'd1:    w_op_b = WIDTH'(4);
            2'd2:    w_op_b = w_sext;
            default: w_op_b = {w_sext[WIDTH-3:0], 2'b00};
        endcase
    end

    always_comb begin
        w_result = w_op_a;
        w_ovf    = 1'b0;
        case (alu_op_t'(alu_op))
            OP_LOAD: w_result = w_op_a;
            OP_ADD: begin
                w_result = w_op_a + w_op_b;
                w_ovf    = (w_op_a[MSB] == w_op_b[MSB]) && (w_result[MSB] != w_op_a[MSB]);
            end
            OP_SUB: begin
                w_result = w_op_a - w_op_b;
                w_ovf    = (w_op_a[MSB] != w_op_b[MSB]) && (w_result[MSB] != w_op_a[MSB]);
            end
            OP_AND:  w_result = w_op_a & w_op_b;
            OP_INC: begin
                w_result = w_op_a + WIDTH'(1);
                w_ovf    = (w_op_a == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_NEG:  w_result = ~w_op_a;
            OP_XOR:  w_result = w_op_a ^ w_op_b;
            OP_COMP: w_result = w_op_a;
            default: w_result = w_op_a;
        endcase
    end

    assign alu_result = w_result;
    assign alu_ovf    = w_ovf;
    assign alu_zero   = (w_result == '0);
    assign alu_eq     = (w_op_a == w_op_b);
    assign alu_gt     = ($signed(w_op_a) > $signed(w_op_b));
    assign alu_lt     = ($signed(w_op_a) < $signed(w_op_b));

    // Entry 0 is never written, so it reads zero without a special read path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (reg_write && (w_dst != '0)) begin
            r_rf[w_dst] <= w_wdata;
        end
    end

    // A/B read the pre-edge file contents, so a same-cycle write is seen one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc     <= PC_RESET;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            r_mdr    <= mem_rdata;
            r_a      <= r_rf[w_rs];
            r_b      <= r_rf[w_rt];
            r_aluout <= w_result;
            if (pc_write) begin
                r_pc <= w_result;
            end
            if (ir_write) begin
                r_ir <= mem_rdata;
            end
        end
    end

    assign mem_addr  = iord ? r_aluout : r_pc;
    assign mem_wdata = r_b;
    assign mem_we    = mem_wr;
    assign opcode    = r_ir[31:26];
    assign funct     = r_ir[5:0];

endmodule
